// File: rtl/otter_ir_pipeline_chain.sv
// otter_ir_pipeline_chain
// Producer side of the OTTER per-stage instruction registers. Owns the PC,
// the single-outstanding instruction-fetch handshake and the DEC/EXE/MEM/WB
// IR pipeline. Redirects and CLEAR flush DEC/EXE; STALL holds PC and DEC and
// injects a bubble into EXE. Bubbles always carry NOP_IR with VALID low.
//
// Ports:
//   CLK, RST_N            clock, asynchronous active-low reset
//   PC_SOURCE             next-PC select (0 PC+4, 1 JALR, 2 BRANCH, 3 JAL,
//                         4 MTVEC, 5 MEPC, 6/7 as 0)
//   JALR_ADDR..MEPC       redirect targets
//   CLEAR, STALL          flush younger stages / load-use hold
//   IMEM_REQ, IMEM_ADDR   fetch request and address (address = PC)
//   IMEM_RDATA/VALID      fetch response for the oldest outstanding request
//   *_IR, *_PC, *_VALID   stage instruction registers, PCs, valid flags
module otter_ir_pipeline_chain #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] NOP_IR    = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [2:0]  PC_SOURCE,
  input  logic [31:0] JALR_ADDR,
  input  logic [31:0] BRANCH_ADDR,
  input  logic [31:0] JAL_ADDR,
  input  logic [31:0] MTVEC,
  input  logic [31:0] MEPC,
  input  logic        CLEAR,
  input  logic        STALL,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic [31:0] IMEM_RDATA,
  input  logic        IMEM_VALID,
  output logic [31:0] DEC_IR,
  output logic [31:0] EXE_IR,
  output logic [31:0] MEM_IR,
  output logic [31:0] WB_IR,
  output logic [31:0] DEC_PC,
  output logic [31:0] EXE_PC,
  output logic        DEC_VALID,
  output logic        EXE_VALID,
  output logic        MEM_VALID,
  output logic        WB_VALID
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2
  } fetch_state_t;

  fetch_state_t state, state_nx;
  logic [31:0]  pc;
  logic         redirect;
  logic         flush;
  logic         accept;
  logic [31:0]  target;

  assign IMEM_ADDR = pc;
  // Gated by RST_N so no request is presented while reset is asserted.
  assign IMEM_REQ  = RST_N & (state != DROP);

  always_comb begin
    redirect = (PC_SOURCE >= 3'd1) && (PC_SOURCE <= 3'd5);
    flush    = redirect | CLEAR;
    accept   = (state != DROP) & IMEM_VALID;
    case (PC_SOURCE)
      3'd1:    target = {JALR_ADDR[31:1], 1'b0};
      3'd2:    target = BRANCH_ADDR;
      3'd3:    target = JAL_ADDR;
      3'd4:    target = MTVEC;
      3'd5:    target = MEPC;
      default: target = pc;
    endcase
  end

  // A response always retires the outstanding request. Without one, a flush
  // leaves the request in flight, so its eventual data must be swallowed.
  always_comb begin
    state_nx = state;
    case (state)
      DROP: begin
        if (IMEM_VALID) state_nx = FETCH;
      end
      default: begin
        if (IMEM_VALID)  state_nx = FETCH;
        else if (flush)  state_nx = DROP;
        else             state_nx = WAIT;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= FETCH;
      pc        <= RESET_VEC;
      DEC_IR    <= NOP_IR;
      EXE_IR    <= NOP_IR;
      MEM_IR    <= NOP_IR;
      WB_IR     <= NOP_IR;
      DEC_PC    <= '0;
      EXE_PC    <= '0;
      DEC_VALID <= 1'b0;
      EXE_VALID <= 1'b0;
      MEM_VALID <= 1'b0;
      WB_VALID  <= 1'b0;
    end else begin
      state     <= state_nx;
      MEM_IR    <= EXE_IR;
      MEM_VALID <= EXE_VALID;
      WB_IR     <= MEM_IR;
      WB_VALID  <= MEM_VALID;
      if (flush) begin
        if (redirect) pc <= target;
        DEC_IR    <= NOP_IR;
        DEC_PC    <= '0;
        DEC_VALID <= 1'b0;
        EXE_IR    <= NOP_IR;
        EXE_PC    <= '0;
        EXE_VALID <= 1'b0;
      end else if (STALL) begin
        EXE_IR    <= NOP_IR;
        EXE_PC    <= '0;
        EXE_VALID <= 1'b0;
      end else begin
        EXE_IR    <= DEC_IR;
        EXE_PC    <= DEC_PC;
        EXE_VALID <= DEC_VALID;
        if (accept) begin
          DEC_IR    <= IMEM_RDATA;
          DEC_PC    <= pc;
          DEC_VALID <= 1'b1;
          pc        <= pc + 32'd4;
        end else begin
          DEC_IR    <= NOP_IR;
          DEC_PC    <= '0;
          DEC_VALID <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/otter_ir_pipeline_chain.md
Name: otter_ir_pipeline_chain

Overview:
- Producer side of the per-stage instruction registers that the OTTER stage decoders consume.
- Owns the PC, the instruction-fetch handshake, and the DEC/EXE/MEM/WB IR and PC pipeline registers.
- Applies PC_SOURCE redirects, CLEAR flushes and hazard stalls, inserting NOP bubbles so that downstream decoders only ever see legal instructions.

Parameters:
RESET_VEC, 32'h00000000, PC value loaded on reset.
NOP_IR, 32'h00000013, bubble instruction (addi x0,x0,0).

Ports:
CLK  in  1  system clock, all state updates on rising edge.
RST_N  in  1  reset, asynchronous, active-low.
PC_SOURCE  in  3  next-PC select from execute decoder: 0 PC+4, 1 JALR, 2 BRANCH, 3 JAL, 4 MTVEC, 5 MEPC; 6 and 7 are treated as 0.
JALR_ADDR, BRANCH_ADDR, JAL_ADDR, MTVEC, MEPC  in  32 each  redirect targets.
CLEAR  in  1  flush the younger stages (DEC, fetch).
STALL  in  1  load-use hazard: hold PC and DEC, inject a bubble into EXE.
IMEM_REQ  out  1  fetch request.
IMEM_ADDR  out  32  fetch address (equals PC).
IMEM_RDATA  in  32  fetched instruction.
IMEM_VALID  in  1  IMEM_RDATA valid for the oldest outstanding request.
DEC_IR, EXE_IR, MEM_IR, WB_IR  out  32 each  stage instruction registers.
DEC_PC, EXE_PC  out  32 each  stage PCs.
DEC_VALID, EXE_VALID, MEM_VALID, WB_VALID  out  1 each  stage holds a real instruction, not a bubble.

Behaviour:
Reset (async, RST_N low):
- PC=RESET_VEC, IMEM_REQ=0.
- All *_IR = NOP_IR; all *_PC = 0; all *_VALID = 0.
- FSM = FETCH.
- Reset mid-wait abandons the outstanding fetch; no IMEM_VALID is consumed until the first post-reset request.

Fetch FSM, states FETCH, WAIT, DROP:
- FETCH: IMEM_REQ=1, IMEM_ADDR=PC.
  - IMEM_VALID the same cycle: instruction accepted.
  - Otherwise go to WAIT.
- WAIT: IMEM_REQ=1, address held stable; accept on IMEM_VALID, then return to FETCH.
- DROP: entered on a redirect or CLEAR while a request is outstanding.
  - IMEM_REQ=0.
  - The next IMEM_VALID is discarded; then go to FETCH at the new PC.
- Memory latency is 0..N cycles; exactly one request is outstanding at a time.

Per-cycle update, precedence redirect/CLEAR > STALL > normal. A redirect is PC_SOURCE in 1..5.
- Redirect:
  - PC <= selected target.
  - DEC_IR <= NOP_IR, DEC_VALID <= 0.
  - EXE receives a bubble.
  - MEM <= EXE (the branch/jump itself advances); WB <= MEM.
  - Any fetched data this cycle is discarded; an outstanding request goes to DROP.
- CLEAR with PC_SOURCE=0: same flush of DEC and EXE, PC <= PC+4 of the discarded fetch is NOT applied, PC holds.
- STALL (no redirect/CLEAR):
  - PC, DEC_IR, DEC_PC and DEC_VALID hold.
  - EXE <= bubble; MEM <= EXE; WB <= MEM.
  - Accepted IMEM data is not consumed; the FSM re-requests the same PC after STALL drops.
- Normal:
  - Instruction accepted: DEC <= {IMEM_RDATA, PC, 1}, PC <= PC+4 (32-bit wrap, 32'hFFFFFFFC+4 = 0).
  - No instruction accepted: DEC <= bubble.
  - EXE <= DEC, MEM <= EXE, WB <= MEM.
- Targets are used as given. Bit 0 of JALR_ADDR is forced to 0; misalignment is not otherwise checked.
- Redirect + STALL + IMEM_VALID all in one cycle: the redirect wins, the data is dropped, and the stall is ignored for that cycle.
- Bubble invariant: whenever *_VALID=0, the matching *_IR = NOP_IR.

Test Plan:
- Reset release, IMEM_VALID tied 1, sequential words I0..I3 at 0,4,8,C -> IMEM_ADDR 0,4,8,C on consecutive cycles; I0 reaches WB_IR 4 cycles after first accept; all VALIDs 1 from cycle 4.
- PC_SOURCE=2, BRANCH_ADDR=0x100, when the branch is in EXE -> next IMEM_ADDR=0x100; DEC_IR=NOP and EXE_IR=NOP the following cycle; branch IR in MEM_IR.
- STALL high 2 cycles with DEC_IR=I5 -> DEC_IR holds I5 and PC holds; EXE_IR=NOP both cycles; MEM/WB keep draining.
- IMEM latency 3 cycles, redirect (PC_SOURCE=3, JAL_ADDR=0x40) during WAIT -> FSM enters DROP; the stale IMEM_VALID is ignored; next request is to 0x40; no stale IR enters DEC.
- RST_N low mid-WAIT for 1 cycle -> all IRs NOP and VALIDs 0 immediately (async); fetch restarts at RESET_VEC.
- PC=0xFFFFFFFC, normal fetch -> next IMEM_ADDR=0x00000000; PC_SOURCE=6 behaves as PC+4.
